// File: rtl/operator_drain_pkg.sv
// Shared types and constants for the operator result drain.
package operator_drain_pkg;
    typedef enum logic {SER_LO, SER_HI} ser_state_t;
    typedef logic [63:0] result_t;
    localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/operator_result_drain_if.sv
// 32-bit valid/ready output stream carrying results as low/high word pairs.
interface operator_result_drain_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/operator_drain_fifo.sv
// DEPTH-entry result FIFO; pointers carry an extra MSB so level/full/empty
// fall straight out of the pointer difference.
module operator_drain_fifo
    import operator_drain_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  result_t          wr_data,
    output result_t          head,
    output logic [CNT_W-1:0] level,
    output logic             full,
    output logic             empty
);
    localparam int AW = CNT_W - 1;

    result_t          mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign head  = mem[rd_ptr_q[AW-1:0]];
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == CNT_W'(DEPTH));
    assign empty = (level == '0);
endmodule

// File: rtl/operator_result_drain.sv
// Buffers 64-bit operator results and streams them out as low/high 32-bit words.
// Optional OPRES_DROP_CNT_EN adds a saturating drop_cnt output.
module operator_result_drain
    import operator_drain_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  result_t                 z,
    input  logic                    z_valid,
    input  logic                    flush,
    operator_result_drain_if.master out_if,
    output logic [CNT_W-1:0]        level,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow
`ifdef OPRES_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]   drop_cnt
`endif
);
    ser_state_t state_q, state_d;
    logic       overflow_q, overflow_d;
    result_t    head;
    logic       handshake, pop, push, drop;

    operator_drain_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (z),
        .head    (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    // A full FIFO still accepts when the high-word handshake frees the head slot.
    assign handshake = out_if.out_valid && out_if.out_ready;
    assign pop       = handshake && (state_q == SER_HI) && !flush;
    assign push      = z_valid && !flush && (!full || pop);
    assign drop      = z_valid && !flush && !push;

    assign out_if.out_valid = !empty;
    assign out_if.out_last  = !empty && (state_q == SER_HI);
    assign out_if.out_data  = empty ? 32'h0 :
                              (state_q == SER_HI) ? head[63:32] : head[31:0];

    // NOTE: next-state is computed in always_comb with a default first so no latch
    // is inferred; the flops below take it with non-blocking assignments only.
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q | drop;
        if (flush) begin
            state_d    = SER_LO;
            overflow_d = 1'b0;
        end else if (handshake) begin
            state_d = (state_q == SER_LO) ? SER_HI : SER_LO;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SER_LO;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef OPRES_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_cnt_q <= '0;
        else      drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_operator_result_drain.sv
// Self-checking bench for operator_result_drain: directed scenarios plus a
// randomized run against a queue-based model of the result stream.
module tb_operator_result_drain;
    import operator_drain_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    result_t          z = '0;
    logic             z_valid = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] level;
    logic             full, empty, overflow;
`ifdef OPRES_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    operator_result_drain_if sif ();

    operator_result_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .z        (z),
        .z_valid  (z_valid),
        .flush    (flush),
        .out_if   (sif),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
`ifdef OPRES_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: queue of stored results, which half of the head is on the bus,
    // sticky overflow flag and drop count.
    result_t mq[$];
    bit      m_hi;
    bit      m_ovf;
    int      m_drop;

    logic [40:0] obs_vec;
    assign obs_vec = {sif.out_valid, sif.out_last, sif.out_data, level, full, empty, overflow};

    function automatic logic [40:0] model_vec();
        logic [31:0] d = 32'h0;
        logic        v = (mq.size() > 0);
        logic        l = 1'b0;
        if (v) begin
            d = m_hi ? mq[0][63:32] : mq[0][31:0];
            l = m_hi;
        end
        return {v, l, d, CNT_W'(mq.size()), (mq.size() == DEPTH), (mq.size() == 0), m_ovf};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_hi   = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic model_clock();
        int sz = mq.size();
        bit popping;
        if (flush) begin
            model_reset();
            return;
        end
        popping = (sz > 0) && sif.out_ready && m_hi;
        if ((sz > 0) && sif.out_ready) m_hi = !m_hi;
        if (popping) void'(mq.pop_front());
        if (z_valid) begin
            if (sz < DEPTH || popping) begin
                mq.push_back(z);
            end else begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    function automatic result_t rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        logic [40:0] exp_v;
        model_reset();
        rst = 1'b0;
        #22;
        exp_v = {1'b0, 1'b0, 32'h0, CNT_W'(0), 1'b0, 1'b1, 1'b0};
        tests_run++;
        if (obs_vec !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected %h", obs_vec, exp_v);
        end
`ifdef OPRES_DROP_CNT_EN
        tests_run++;
        if (drop_cnt !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_drop_cnt: got %h expected 0", drop_cnt);
        end
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        sif.out_ready = 1'b1;
        z       = 64'h1122334455667788;
        z_valid = 1'b1;
        step();
        z_valid = 1'b0;
        tests_run++;
        if ({sif.out_valid, sif.out_last, sif.out_data} !== {1'b1, 1'b0, 32'h55667788}) begin
            tests_failed++;
            $display("FAIL single_low: got v=%b l=%b d=%h expected v=1 l=0 d=55667788",
                     sif.out_valid, sif.out_last, sif.out_data);
        end
        step();
        tests_run++;
        if ({sif.out_valid, sif.out_last, sif.out_data} !== {1'b1, 1'b1, 32'h11223344}) begin
            tests_failed++;
            $display("FAIL single_high: got v=%b l=%b d=%h expected v=1 l=1 d=11223344",
                     sif.out_valid, sif.out_last, sif.out_data);
        end
        step();
        tests_run++;
        if ({empty, sif.out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_empty: got empty=%b valid=%b expected empty=1 valid=0",
                     empty, sif.out_valid);
        end
    endtask

    task automatic test_back_pressure();
        result_t     res [3];
        logic [31:0] exp_w;
        sif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            res[i]  = rand64();
            z       = res[i];
            z_valid = 1'b1;
            step();
        end
        z_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if ({level, sif.out_valid, sif.out_last, sif.out_data} !== {CNT_W'(3), 1'b1, 1'b0, res[0][31:0]}) begin
                tests_failed++;
                $display("FAIL bp_hold: got level=%0d d=%h l=%b expected level=3 d=%h l=0",
                         level, sif.out_data, sif.out_last, res[0][31:0]);
            end
            step();
        end
        sif.out_ready = 1'b1;
        for (int w = 0; w < 6; w++) begin
            exp_w = w[0] ? res[w/2][63:32] : res[w/2][31:0];
            tests_run++;
            if ({sif.out_valid, sif.out_last, sif.out_data} !== {1'b1, w[0], exp_w}) begin
                tests_failed++;
                $display("FAIL bp_word%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                         w, sif.out_valid, sif.out_last, sif.out_data, w[0], exp_w);
            end
            step();
        end
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_overflow();
        result_t     res [10];
        logic [31:0] exp_w;
        sif.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            res[i]  = rand64();
            z       = res[i];
            z_valid = 1'b1;
            step();
        end
        z_valid = 1'b0;
        tests_run++;
        if ({level, full, overflow} !== {CNT_W'(8), 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL ovf_status: got level=%0d full=%b ovf=%b expected level=8 full=1 ovf=1",
                     level, full, overflow);
        end
`ifdef OPRES_DROP_CNT_EN
        tests_run++;
        if (drop_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt);
        end
`endif
        sif.out_ready = 1'b1;
        for (int w = 0; w < 16; w++) begin
            exp_w = w[0] ? res[w/2][63:32] : res[w/2][31:0];
            tests_run++;
            if ({sif.out_valid, sif.out_last, sif.out_data} !== {1'b1, w[0], exp_w}) begin
                tests_failed++;
                $display("FAIL ovf_word%0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                         w, sif.out_valid, sif.out_last, sif.out_data, w[0], exp_w);
            end
            step();
        end
        tests_run++;
        if ({empty, overflow} !== 2'b11) begin
            tests_failed++;
            $display("FAIL ovf_drained: got empty=%b ovf=%b expected empty=1 ovf=1", empty, overflow);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_full_pop();
        sif.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            z       = rand64();
            z_valid = 1'b1;
            step();
        end
        z_valid       = 1'b0;
        sif.out_ready = 1'b1;
        step();
        tests_run++;
        if ({level, sif.out_last} !== {CNT_W'(8), 1'b1}) begin
            tests_failed++;
            $display("FAIL fullpop_pre: got level=%0d last=%b expected level=8 last=1", level, sif.out_last);
        end
        z       = rand64();
        z_valid = 1'b1;
        step();
        z_valid = 1'b0;
        tests_run++;
        if ({level, full, overflow} !== {CNT_W'(8), 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL fullpop_post: got level=%0d full=%b ovf=%b expected level=8 full=1 ovf=0",
                     level, full, overflow);
        end
        for (int c = 0; c < 2 * DEPTH + 1; c++) begin
            tests_run++;
            if (obs_vec !== model_vec()) begin
                tests_failed++;
                $display("FAIL fullpop_drain c%0d: got %h expected %h", c, obs_vec, model_vec());
            end
            step();
        end
    endtask

    task automatic test_flush_mid();
        result_t r;
        sif.out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            z       = rand64();
            z_valid = 1'b1;
            step();
        end
        z_valid       = 1'b0;
        sif.out_ready = 1'b1;
        step();
        flush   = 1'b1;
        z       = rand64();
        z_valid = 1'b1;
        step();
        flush   = 1'b0;
        z_valid = 1'b0;
        tests_run++;
        if ({empty, sif.out_valid, overflow, level} !== {1'b1, 1'b0, 1'b0, CNT_W'(0)}) begin
            tests_failed++;
            $display("FAIL flush_state: got empty=%b valid=%b ovf=%b level=%0d expected 1 0 0 0",
                     empty, sif.out_valid, overflow, level);
        end
`ifdef OPRES_DROP_CNT_EN
        tests_run++;
        if (drop_cnt !== 16'h0) begin
            tests_failed++;
            $display("FAIL flush_drop_cnt: got %0d expected 0", drop_cnt);
        end
`endif
        r       = rand64();
        z       = r;
        z_valid = 1'b1;
        step();
        z_valid = 1'b0;
        tests_run++;
        if ({sif.out_last, sif.out_data} !== {1'b0, r[31:0]}) begin
            tests_failed++;
            $display("FAIL flush_ser_lo: got l=%b d=%h expected l=0 d=%h", sif.out_last, sif.out_data, r[31:0]);
        end
        step();
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            z             = rand64();
            z_valid       = ($urandom_range(0, 99) < 60);
            sif.out_ready = ($urandom_range(0, 99) < 50);
            flush         = ($urandom_range(0, 99) < 2);
            #1;
            tests_run++;
            if (obs_vec !== model_vec()) begin
                tests_failed++;
                $display("FAIL random c%0d: got %h expected %h", c, obs_vec, model_vec());
            end
`ifdef OPRES_DROP_CNT_EN
            tests_run++;
            if (drop_cnt !== m_drop[15:0]) begin
                tests_failed++;
                $display("FAIL random_drop c%0d: got %0d expected %0d", c, drop_cnt, m_drop);
            end
`endif
            step();
        end
        z_valid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic test_async_reset();
        result_t r;
        flush = 1'b1;
        step();
        flush         = 1'b0;
        sif.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            z       = rand64();
            z_valid = 1'b1;
            step();
        end
        z_valid       = 1'b0;
        sif.out_ready = 1'b1;
        step();
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({sif.out_valid, level, empty} !== {1'b0, CNT_W'(0), 1'b1}) begin
            tests_failed++;
            $display("FAIL async_reset: got valid=%b level=%0d empty=%b expected 0 0 1",
                     sif.out_valid, level, empty);
        end
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        r       = rand64();
        z       = r;
        z_valid = 1'b1;
        step();
        z_valid = 1'b0;
        tests_run++;
        if ({sif.out_last, sif.out_data, level} !== {1'b0, r[31:0], CNT_W'(1)}) begin
            tests_failed++;
            $display("FAIL async_after: got l=%b d=%h level=%0d expected l=0 d=%h level=1",
                     sif.out_last, sif.out_data, level, r[31:0]);
        end
    endtask

    initial begin
        sif.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_pressure();
        test_overflow();
        test_full_pop();
        test_flush_mid();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
